// File: rtl/gb_ppu_pkg.sv
// Shared PPU fetch definitions: fetcher state encoding, VRAM layout constants
// and tile geometry. Imported by the background fetcher and the tile address
// helper (and later by the sprite fetcher).
package gb_ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TILE_ID,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WAIT_SPACE,
    ST_PUSH
  } fetch_state_t;

  localparam logic [12:0] VRAM_MAP0_BASE        = 13'h1800;
  localparam logic [12:0] VRAM_MAP1_BASE        = 13'h1C00;
  localparam logic [12:0] VRAM_TILE_SIGNED_BASE = 13'h1000;
  localparam int          TILE_BYTES            = 16;
  localparam int          PIXELS_PER_TILE       = 8;

endpackage

// File: rtl/ppu_tile_addr.sv
// Combinational VRAM address generator for tile fetches.
// Ports:
//   map_sel   - 0: map at 0x1800, 1: map at 0x1C00
//   data_sel  - 1: unsigned tile IDs from 0x0000, 0: signed IDs around 0x1000
//   line      - effective line; [7:3] picks the map row, [2:0] the row in the tile
//   col       - tile column in the map
//   id        - tile ID read from the map
//   hi        - 1 selects the high bitplane byte (address + 1)
//   map_addr  - 13-bit tile map address
//   data_addr - 13-bit tile bitplane address
module ppu_tile_addr
  import gb_ppu_pkg::*;
(
  input  logic        map_sel,
  input  logic        data_sel,
  input  logic [7:0]  line,
  input  logic [4:0]  col,
  input  logic [7:0]  id,
  input  logic        hi,
  output logic [12:0] map_addr,
  output logic [12:0] data_addr
);

  logic [12:0] tile_base;
  logic [12:0] row_off;

  assign map_addr = (map_sel ? VRAM_MAP1_BASE : VRAM_MAP0_BASE) | {3'b000, line[7:3], col};

  // Signed mode sign-extends the ID and lets the 13-bit sum wrap, so 0x80..0xFF
  // land below 0x1000 (block 1) and 0x00..0x7F above it (block 2).
  always_comb begin
    if (data_sel)
      tile_base = {5'd0, id} * 13'(TILE_BYTES);
    else
      tile_base = VRAM_TILE_SIGNED_BASE + {{5{id[7]}}, id} * 13'(TILE_BYTES);
  end

  // Two bytes per pixel row; the high plane is the odd byte.
  assign row_off   = {8'd0, line[2:0], 1'b0} + {12'd0, hi};
  assign data_addr = tile_base + row_off;

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: writer side of the BG pixel FIFO. For each tile of a
// scanline it reads the tile ID, low and high bitplanes from VRAM (2 cycles
// each), waits until the FIFO can absorb a full tile, then pushes 8 2-bit
// colour indices, leftmost pixel first.
// Ports:
//   clk_in, rst_in        - clock, async active-high reset
//   start_in / stop_in    - begin a scanline (IDLE only) / synchronous abort (wins)
//   line_in, tile_col_in  - effective BG line and first tile column, sampled at start
//   map_sel_in, data_sel_in - map and tile-data addressing modes, sampled at start
//   vram_rd_out, vram_addr_out, vram_data_in - VRAM read port (data 1 cycle after strobe)
//   fifo_count_in         - downstream FIFO occupancy
//   fifo_wr_out, pixel_out - FIFO write port
//   busy_out, done_out    - line in progress / 1-cycle end-of-line pulse
module bg_tile_fetcher
  import gb_ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_TILES = 21
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic                        stop_in,
  input  logic [7:0]                  line_in,
  input  logic [4:0]                  tile_col_in,
  input  logic                        map_sel_in,
  input  logic                        data_sel_in,
  output logic                        vram_rd_out,
  output logic [12:0]                 vram_addr_out,
  input  logic [7:0]                  vram_data_in,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_count_in,
  output logic                        fifo_wr_out,
  output logic [1:0]                  pixel_out,
  output logic                        busy_out,
  output logic                        done_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(LINE_TILES + 1);
  localparam logic [CW-1:0] SPACE_MAX = CW'(FIFO_DEPTH - PIXELS_PER_TILE);

  fetch_state_t  state;
  logic          phase;     // 0: read strobe cycle, 1: data capture cycle
  logic [7:0]    line_q;
  logic [4:0]    col_q;
  logic          map_sel_q;
  logic          data_sel_q;
  logic [7:0]    id_q;
  logic [7:0]    lo_q;      // shifted left per pushed pixel; bit 7 is current
  logic [7:0]    hi_q;
  logic [2:0]    pix_idx;
  logic [TW-1:0] tile_cnt;

  logic [12:0]   map_addr;
  logic [12:0]   data_addr;
  logic          has_space;
  logic          last_pix;
  logic          last_tile;

  ppu_tile_addr u_addr (
    .map_sel   (map_sel_q),
    .data_sel  (data_sel_q),
    .line      (line_q),
    .col       (col_q),
    .id        (id_q),
    .hi        (state == ST_DATA_HI),
    .map_addr  (map_addr),
    .data_addr (data_addr)
  );

  // Reader only drains, so room for 8 now means 8 back-to-back writes are safe.
  assign has_space = fifo_count_in <= SPACE_MAX;
  assign last_pix  = pix_idx == 3'(PIXELS_PER_TILE - 1);
  assign last_tile = tile_cnt == TW'(LINE_TILES - 1);

  // Address and pixel are muxed from registered state and forced to 0 when
  // their strobe is low, keeping the bus quiet in IDLE and after reset.
  assign vram_addr_out = vram_rd_out ? ((state == ST_TILE_ID) ? map_addr : data_addr) : 13'd0;
  assign pixel_out     = fifo_wr_out ? {hi_q[7], lo_q[7]} : 2'b00;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      line_q      <= '0;
      col_q       <= '0;
      map_sel_q   <= 1'b0;
      data_sel_q  <= 1'b0;
      id_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      pix_idx     <= '0;
      tile_cnt    <= '0;
      vram_rd_out <= 1'b0;
      fifo_wr_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (stop_in) begin
        state       <= ST_IDLE;
        phase       <= 1'b0;
        vram_rd_out <= 1'b0;
        fifo_wr_out <= 1'b0;
        busy_out    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_in) begin
              line_q      <= line_in;
              col_q       <= tile_col_in;
              map_sel_q   <= map_sel_in;
              data_sel_q  <= data_sel_in;
              tile_cnt    <= '0;
              busy_out    <= 1'b1;
              state       <= ST_TILE_ID;
              phase       <= 1'b0;
              vram_rd_out <= 1'b1;
            end
          end

          ST_TILE_ID, ST_DATA_LO, ST_DATA_HI: begin
            if (!phase) begin
              phase       <= 1'b1;
              vram_rd_out <= 1'b0;
            end else begin
              phase <= 1'b0;
              case (state)
                ST_TILE_ID: begin
                  id_q        <= vram_data_in;
                  state       <= ST_DATA_LO;
                  vram_rd_out <= 1'b1;
                end
                ST_DATA_LO: begin
                  lo_q        <= vram_data_in;
                  state       <= ST_DATA_HI;
                  vram_rd_out <= 1'b1;
                end
                default: begin
                  // Skip WAIT_SPACE when room is already there: 14-cycle tiles.
                  hi_q <= vram_data_in;
                  if (has_space) begin
                    state       <= ST_PUSH;
                    fifo_wr_out <= 1'b1;
                    pix_idx     <= '0;
                  end else begin
                    state <= ST_WAIT_SPACE;
                  end
                end
              endcase
            end
          end

          ST_WAIT_SPACE: begin
            if (has_space) begin
              state       <= ST_PUSH;
              fifo_wr_out <= 1'b1;
              pix_idx     <= '0;
            end
          end

          ST_PUSH: begin
            lo_q    <= {lo_q[6:0], 1'b0};
            hi_q    <= {hi_q[6:0], 1'b0};
            pix_idx <= pix_idx + 3'd1;
            if (last_pix) begin
              fifo_wr_out <= 1'b0;
              col_q       <= col_q + 5'd1;
              tile_cnt    <= tile_cnt + TW'(1);
              phase       <= 1'b0;
              if (last_tile) begin
                state    <= ST_IDLE;
                busy_out <= 1'b0;
                done_out <= 1'b1;
              end else begin
                state       <= ST_TILE_ID;
                vram_rd_out <= 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher with a simple VRAM responder model.
module tb_bg_tile_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic [7:0]  line_in = '0;
  logic [4:0]  tile_col_in = '0;
  logic        map_sel_in = 1'b0;
  logic        data_sel_in = 1'b0;
  logic        vram_rd_out;
  logic [12:0] vram_addr_out;
  logic [7:0]  vram_data_in = '0;
  logic [4:0]  fifo_count_in = '0;
  logic        fifo_wr_out;
  logic [1:0]  pixel_out;
  logic        busy_out;
  logic        done_out;

  bg_tile_fetcher #(.FIFO_DEPTH(16), .LINE_TILES(21)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .line_in       (line_in),
    .tile_col_in   (tile_col_in),
    .map_sel_in    (map_sel_in),
    .data_sel_in   (data_sel_in),
    .vram_rd_out   (vram_rd_out),
    .vram_addr_out (vram_addr_out),
    .vram_data_in  (vram_data_in),
    .fifo_count_in (fifo_count_in),
    .fifo_wr_out   (fifo_wr_out),
    .pixel_out     (pixel_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] vram [0:8191];

  // VRAM: data valid the cycle after the strobe.
  always @(posedge clk_in) vram_data_in <= vram_rd_out ? vram[vram_addr_out] : 8'h00;

  int wr_cnt = 0;
  int done_cnt = 0;
  int overlap = 0;
  logic [12:0] rd_log [$];

  always @(negedge clk_in) begin
    if (fifo_wr_out) wr_cnt <= wr_cnt + 1;
    if (done_out) done_cnt <= done_cnt + 1;
    if (vram_rd_out && fifo_wr_out) overlap <= overlap + 1;
    if (vram_rd_out) rd_log.push_back(vram_addr_out);
  end

  int passes = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Returns in the first cycle of the line (map read strobe).
  task automatic start_line(input logic [7:0] line, input logic [4:0] col,
                            input logic map, input logic dsel);
    line_in = line; tile_col_in = col; map_sel_in = map; data_sel_in = dsel;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic abort();
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
  endtask

  task automatic fetch_addrs(input string tag, input logic [7:0] line, input logic [4:0] col,
                             input logic map, input logic dsel,
                             input logic [12:0] emap, input logic [12:0] elo, input logic [12:0] ehi);
    start_line(line, col, map, dsel);
    chk({tag, "_map"}, vram_addr_out, emap);
    tick(); tick();
    chk({tag, "_lo"}, vram_addr_out, elo);
    tick(); tick();
    chk({tag, "_hi"}, vram_addr_out, ehi);
    abort();
  endtask

  initial begin
    int w0, d0, r0, cyc;
    for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
    vram[13'h1800] = 8'h01;
    vram[13'h0010] = 8'hF0;
    vram[13'h0011] = 8'h0F;
    vram[13'h1C02] = 8'h80;
    vram[13'h1C23] = 8'h7F;

    // Reset state
    repeat (2) tick();
    chk("rst_rd", vram_rd_out, 0);
    chk("rst_addr", vram_addr_out, 0);
    chk("rst_wr", fifo_wr_out, 0);
    chk("rst_pix", pixel_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    rst_in = 1'b0;
    tick();

    // Unsigned fetch + push pattern 1,1,1,1,2,2,2,2
    start_line(8'd0, 5'd0, 1'b0, 1'b1);
    chk("t1_busy", busy_out, 1);
    chk("t1_map_rd", vram_rd_out, 1);
    chk("t1_map_addr", vram_addr_out, 13'h1800);
    tick();
    chk("t1_rd_gap", vram_rd_out, 0);
    tick();
    chk("t1_lo_addr", vram_addr_out, 13'h0010);
    tick(); tick();
    chk("t1_hi_addr", vram_addr_out, 13'h0011);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_wr%0d", i), fifo_wr_out, 1);
      chk($sformatf("t2_pix%0d", i), pixel_out, (i < 4) ? 2'd1 : 2'd2);
      tick();
    end
    chk("t2_wr_end", fifo_wr_out, 0);
    chk("t2_next_rd", vram_rd_out, 1);
    chk("t2_next_map", vram_addr_out, 13'h1801);
    abort();
    chk("t2_abort_busy", busy_out, 0);
    chk("t2_abort_rd", vram_rd_out, 0);

    // Signed addressing, map 1, line bits in map row
    fetch_addrs("t3a", 8'd5, 5'd2, 1'b1, 1'b0, 13'h1C02, 13'h080A, 13'h080B);
    fetch_addrs("t3b", 8'd8, 5'd3, 1'b1, 1'b0, 13'h1C23, 13'h17F0, 13'h17F1);

    // FIFO space boundary: 9 holds, 8 releases
    fifo_count_in = 5'd9;
    start_line(8'd0, 5'd0, 1'b0, 1'b1);
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_hold_wr%0d", i), fifo_wr_out, 0);
      chk($sformatf("t4_hold_rd%0d", i), vram_rd_out, 0);
      tick();
    end
    fifo_count_in = 5'd8;
    tick();
    chk("t4_push_wr", fifo_wr_out, 1);
    chk("t4_push_pix", pixel_out, 1);
    abort();
    fifo_count_in = 5'd0;

    // Stop during pixel 3
    start_line(8'd0, 5'd0, 1'b0, 1'b1);
    repeat (9) tick();
    chk("t6_pix3_wr", fifo_wr_out, 1);
    d0 = done_cnt;
    abort();
    chk("t6_stop_wr", fifo_wr_out, 0);
    chk("t6_stop_busy", busy_out, 0);
    chk("t6_stop_done", done_out, 0);
    repeat (3) tick();
    chk("t6_no_done", done_cnt - d0, 0);

    // Start together with stop: stays idle
    start_in = 1'b1; stop_in = 1'b1;
    tick();
    start_in = 1'b0; stop_in = 1'b0;
    chk("t6_ss_busy", busy_out, 0);
    chk("t6_ss_rd", vram_rd_out, 0);

    // Full line from column 31: wrap and done after 21 tiles
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_log.size();
    start_line(8'd0, 5'd31, 1'b0, 1'b1);
    cyc = 1;
    while (!done_out && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("t5_done", done_out, 1);
    chk("t5_done_cycle", cyc, 295);
    chk("t5_busy_at_done", busy_out, 0);
    tick();
    chk("t5_done_pulse", done_out, 0);
    chk("t5_first_map", (rd_log.size() > r0) ? rd_log[r0] : 13'h0, 13'h181F);
    chk("t5_wrap_map", (rd_log.size() > r0 + 3) ? rd_log[r0 + 3] : 13'h0, 13'h1800);
    chk("t5_reads", rd_log.size() - r0, 63);
    chk("t5_writes", wr_cnt - w0, 168);
    chk("t5_done_cnt", done_cnt - d0, 1);

    // Async reset mid-fetch
    start_line(8'd0, 5'd0, 1'b0, 1'b1);
    chk("t6r_rd_before", vram_rd_out, 1);
    #2 rst_in = 1'b1;
    #1;
    chk("t6r_rd", vram_rd_out, 0);
    chk("t6r_addr", vram_addr_out, 0);
    chk("t6r_busy", busy_out, 0);
    tick();
    rst_in = 1'b0;
    tick();
    chk("t6r_idle", busy_out, 0);

    chk("no_rd_wr_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
